display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
// - Scan controller for the 4-digit 7-segment peripheral; drives the digit mux from the other end.
// - Holds the 16-bit display value and presents it as four nibbles (data_o) to the mux data inputs.
// - Steps sel_o through digits 0..3 at the refresh rate and takes the selected nibble back from the mux.
// - Decodes that nibble to active-low segments and drives active-low anodes, with an anti-ghosting blank window.
// PARAMETERS
// - REFRESH_DIV  default 100000  clock cycles per digit slot; legal range >= 4
// - BLANK_CYC    default 1000    cycles per slot with all anodes off after a digit change; 1 <= BLANK_CYC < REFRESH_DIV-1
// PORTS
// - clk_i     in   1   system clock; the only clock
// - rst_i     in   1   synchronous, active-high reset
// - data_i    in   16  display value; nibble k drives digit k (digit 0 = rightmost)
// - we_i      in   1   load strobe; data_i is captured on a clock edge where we_i=1
// - lz_en_i   in   1   1 = blank leading-zero digits
// - nibble_i  in   4   nibble returned by the mux for the current sel_o
// - data_o    out  16  registered display value, feeds mux d0..d3 = data_o[3:0]..[15:12]
// - sel_o     out  2   digit select, drives the mux sel input
// - an_o      out  4   anodes, active low; an_o[k]=0 lights digit k
// - seg_o     out  7   segments, active low, bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
// - Reset values:
//   - cnt_q = 0, sel_o = 0, data_o = 0
//   - an_o = 4'b1111, seg_o = 7'h7F (all off)
// - Prescaler cnt_q:
//   - Counts 0..REFRESH_DIV-1, then wraps to 0.
//   - When cnt_q == REFRESH_DIV-1: next cycle cnt_q = 0 and sel_o = sel_o+1 mod 4 (3 -> 0).
// - Data register: on we_i=1, data_o <= data_i next edge; otherwise it holds.
//   - A write mid-slot takes effect on the digit currently lit; no resynchronisation and no scan restart.
// - seg_o is registered every cycle: seg_o <= hex7(nibble_i).
// - hex7 table, 0..F:
//   - 40 79 24 30 19 12 02 78
//   - 00 10 08 03 46 21 06 0E
// - an_o is registered every cycle, from the current cnt_q and sel_o:
//   - If cnt_q < BLANK_CYC: an_o <= 4'b1111.
//   - Else if blank(sel_o): an_o <= 4'b1111.
//   - Else: an_o <= ~(4'b0001 << sel_o).
// - Lag: an_o and seg_o both lag cnt_q/sel_o by exactly one cycle, so they always describe the same digit.
//   - In the cycle after sel_o changes, the old digit's anode and segments are still shown together.
//   - After that come BLANK_CYC dark cycles, then the new digit.
// - blank(k), evaluated on data_o:
//   - Requires lz_en_i=1, k != 0, and data_o nibbles k..3 all zero.
//   - Digit 0 is never blanked, so value 0 shows a single "0".
// - Mux path: nibble_i is sampled the same cycle sel_o is presented; a combinational mux is assumed on that path.
// - Reset mid-operation (rst_i high on any edge):
//   - All state returns to its reset value on that edge; data_o is cleared.
//   - Scan restarts at sel_o=0, cnt_q=0 after release.
// - Priority: rst_i overrides we_i; we_i and a digit change on the same edge are independent.
// TESTING (sim parameters REFRESH_DIV=8, BLANK_CYC=2; bench models the mux combinationally)
// - Reset: hold rst_i 3 cycles, then release -> an_o=1111, seg_o=7F, sel_o=0, data_o=0000 in the first cycle after release.
// - Scan: we_i pulse with data_i=16'h1234, lz_en_i=0 ->
//   - sel_o steps 0,1,2,3,0 every 8 cycles.
//   - Lit pairs: an 1110/seg 19, an 1101/seg 30, an 1011/seg 24, an 0111/seg 79.
// - Blank window: after each sel_o change -> 1 cycle old digit, exactly 2 cycles an_o=1111, then 5 cycles new digit; never two anodes low.
// - Leading zeros, lz_en_i=1:
//   - data 16'h0008 -> only an_o=1110 ever asserted, seg 00.
//   - data 16'h0000 -> only digit 0 lit, seg 40.
//   - data 16'h0100 -> digits 0..2 lit.
// - Mid-slot write: while digit 0 is lit, write 16'hABCD -> data_o=ABCD next cycle; seg_o=21 one cycle later; scan timing unchanged.
// - Mid-scan reset: 1-cycle rst_i pulse at sel_o=2, cnt_q=5 ->
//   - Next cycle: all reset values.
//   - Then sel_o=0 for 8 cycles, and data_o=0 displays "0000", or only digit 0 if lz_en_i=1.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// It steps the digit mux, decodes the returned nibble and drives the anodes with an anti-ghost blank window.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] data_i,
  input  logic        we_i,
  input  logic        lz_en_i,
  input  logic [3:0]  nibble_i,
  output logic [15:0] data_o,
  output logic [1:0]  sel_o,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic             lead_blank;
  logic [3:0]       an_next;

  // Segment patterns, active low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    // NOTE: default first so every path assigns lead_blank and no latch is inferred.
    lead_blank = 1'b0;
    case (sel_o)
      2'd1:    lead_blank = (data_o[15:4]  == 12'h000);
      2'd2:    lead_blank = (data_o[15:8]  == 8'h00);
      2'd3:    lead_blank = (data_o[15:12] == 4'h0);
      default: lead_blank = 1'b0;
    endcase
    lead_blank = lead_blank & lz_en_i;
  end

  always_comb begin
    an_next = ~(4'b0001 << sel_o);
    if (cnt_q < BLANK_END || lead_blank) an_next = 4'b1111;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      cnt_q  <= '0;
      sel_o  <= 2'd0;
      data_o <= 16'h0000;
      an_o   <= 4'b1111;
      seg_o  <= 7'h7F;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        sel_o <= sel_o + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (we_i) data_o <= data_i;
      // Anode and segments both register the pre-edge digit, so they stay paired.
      an_o  <= an_next;
      seg_o <= hex7(nibble_i);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a time-based reference model.
// The mux is modelled combinationally from data_o and sel_o.
module tb_display_scan_ctrl;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] data_i;
  logic        we_i;
  logic        lz_en_i;
  logic [3:0]  nibble_i;
  logic [15:0] data_o;
  logic [1:0]  sel_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: elapsed cycles since scan restart plus the held display value.
  int          m_t;
  logic [15:0] m_data;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  display_scan_ctrl #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLANK)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .we_i     (we_i),
    .lz_en_i  (lz_en_i),
    .nibble_i (nibble_i),
    .data_o   (data_o),
    .sel_o    (sel_o),
    .an_o     (an_o),
    .seg_o    (seg_o)
  );

  assign nibble_i = data_o[{sel_o, 2'b00} +: 4];

  always #5 clk_i = ~clk_i;

  function automatic logic [1:0] m_sel();
    return 2'((m_t / RDIV) % 4);
  endfunction

  function automatic bit m_blank(input logic [1:0] k);
    return lz_en_i && (k != 2'd0) && ((m_data >> (4 * k)) == 16'h0000);
  endfunction

  function automatic logic [28:0] exp_vec();
    return {m_data, m_sel(), m_an, m_seg};
  endfunction

  // Advance the model by one clock using the inputs currently driven, then wait for the edge.
  task automatic tick();
    logic [1:0] s;
    int         c;
    if (rst_i) begin
      m_t = 0; m_data = 16'h0000; m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      s = m_sel();
      c = m_t % RDIV;
      m_an  = (c < BLANK || m_blank(s)) ? 4'hF : ~(4'b0001 << s);
      m_seg = hex_tab[4'((m_data >> (4 * s)) & 16'hF)];
      if (we_i) m_data = data_i;
      m_t++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; we_i = 1'b0; data_i = 16'h0000; lz_en_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (an_o !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an_o); end
    checks++;
    if (seg_o !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg_o); end
    checks++;
    if (sel_o !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel_o); end
    checks++;
    if (data_o !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] lit_seg [4];
    logic [3:0] lit_seen;
    logic [6:0] want    [4];
    want = '{7'h19, 7'h30, 7'h24, 7'h79};
    lit_seen = 4'b0000;
    data_i = 16'h1234; we_i = 1'b1; lz_en_i = 1'b0;
    tick();
    we_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({data_o, sel_o, an_o, seg_o} !== exp_vec()) begin
        failures++;
        $display("FAIL scan cyc=%0d got data=%h sel=%0d an=%b seg=%h exp data=%h sel=%0d an=%b seg=%h",
                 i, data_o, sel_o, an_o, seg_o, m_data, m_sel(), m_an, m_seg);
      end
      checks++;
      if ($countones(~an_o) > 1) begin failures++; $display("FAIL ghost cyc=%0d got an=%b exp at most one low", i, an_o); end
      for (int k = 0; k < 4; k++)
        if (an_o == ~(4'b0001 << k)) begin lit_seg[k] = seg_o; lit_seen[k] = 1'b1; end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!lit_seen[k] || lit_seg[k] !== want[k]) begin
        failures++;
        $display("FAIL scan_pair digit=%0d got seen=%b seg=%h exp seg=%h", k, lit_seen[k], lit_seg[k], want[k]);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals  [3];
    logic [3:0]  lit_x [3];
    logic [3:0]  seen;
    vals  = '{16'h0008, 16'h0000, 16'h0100};
    lit_x = '{4'b0001, 4'b0001, 4'b0111};
    for (int v = 0; v < 3; v++) begin
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      lz_en_i = 1'b1; data_i = vals[v]; we_i = 1'b1;
      tick();
      we_i = 1'b0;
      seen = 4'b0000;
      for (int i = 0; i < 40; i++) begin
        tick();
        seen |= ~an_o;
        checks++;
        if ({data_o, sel_o, an_o, seg_o} !== exp_vec()) begin
          failures++;
          $display("FAIL lz val=%h cyc=%0d got an=%b seg=%h sel=%0d exp an=%b seg=%h sel=%0d",
                   vals[v], i, an_o, seg_o, sel_o, m_an, m_seg, m_sel());
        end
      end
      checks++;
      if (seen !== lit_x[v]) begin
        failures++;
        $display("FAIL lz_digits val=%h got lit=%b exp lit=%b", vals[v], seen, lit_x[v]);
      end
    end
    lz_en_i = 1'b0;
  endtask

  task automatic test_midslot_write();
    int budget;
    data_i = 16'h5678; we_i = 1'b1; tick(); we_i = 1'b0;
    budget = 0;
    while (m_t % (4 * RDIV) != 3 && budget < 100) begin tick(); budget++; end
    checks++;
    if (budget >= 100) begin failures++; $display("FAIL midslot_wait got timeout exp slot0 cnt3"); end
    data_i = 16'hABCD; we_i = 1'b1;
    tick();
    we_i = 1'b0;
    checks++;
    if (data_o !== 16'hABCD) begin failures++; $display("FAIL midslot_data got=%h exp=abcd", data_o); end
    tick();
    checks++;
    if (seg_o !== 7'h21 || an_o !== 4'b1110) begin
      failures++;
      $display("FAIL midslot_seg got seg=%h an=%b exp seg=21 an=1110", seg_o, an_o);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if ({data_o, sel_o, an_o, seg_o} !== exp_vec()) begin
        failures++;
        $display("FAIL midslot_scan cyc=%0d got sel=%0d an=%b seg=%h exp sel=%0d an=%b seg=%h",
                 i, sel_o, an_o, seg_o, m_sel(), m_an, m_seg);
      end
    end
  endtask

  task automatic test_midscan_reset();
    int budget;
    for (int lz = 0; lz < 2; lz++) begin
      lz_en_i = lz[0];
      data_i = 16'h9F3E; we_i = 1'b1; tick(); we_i = 1'b0;
      budget = 0;
      while (m_t % (4 * RDIV) != 2 * RDIV + 5 && budget < 100) begin tick(); budget++; end
      checks++;
      if (budget >= 100 || sel_o !== 2'd2) begin
        failures++;
        $display("FAIL midreset_wait got sel=%0d budget=%0d exp sel=2", sel_o, budget);
      end
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      checks++;
      if ({data_o, sel_o, an_o, seg_o} !== {16'h0000, 2'd0, 4'b1111, 7'h7F}) begin
        failures++;
        $display("FAIL midreset_vals got data=%h sel=%0d an=%b seg=%h exp 0000 0 1111 7f",
                 data_o, sel_o, an_o, seg_o);
      end
      for (int i = 0; i < 4 * RDIV; i++) begin
        tick();
        checks++;
        if ({data_o, sel_o, an_o, seg_o} !== exp_vec() || (i < RDIV - 1 && sel_o !== 2'd0)) begin
          failures++;
          $display("FAIL midreset_scan lz=%0d cyc=%0d got sel=%0d an=%b seg=%h exp sel=%0d an=%b seg=%h",
                   lz, i, sel_o, an_o, seg_o, m_sel(), m_an, m_seg);
        end
      end
    end
    lz_en_i = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_i   = ($urandom_range(0, 59) == 0);
      we_i    = ($urandom_range(0, 9) == 0);
      data_i  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255) << (4 * $urandom_range(0, 2)));
      if ($urandom_range(0, 49) == 0) lz_en_i = ~lz_en_i;
      tick();
      checks++;
      if ({data_o, sel_o, an_o, seg_o} !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got data=%h sel=%0d an=%b seg=%h exp data=%h sel=%0d an=%b seg=%h",
                 i, data_o, sel_o, an_o, seg_o, m_data, m_sel(), m_an, m_seg);
      end
    end
    rst_i = 1'b0; we_i = 1'b0;
  endtask

  initial begin
    m_t = 0; m_data = 16'h0000; m_an = 4'hF; m_seg = 7'h7F;
    rst_i = 1'b1; we_i = 1'b0; data_i = 16'h0000; lz_en_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_scan();
    test_leading_zero();
    test_midslot_write();
    test_midscan_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
